// File: rtl/tdc_framer.sv
// tdc_framer
//   Time-to-digital interval counter with a byte-stream framer. A rising edge
//   on start arms the counter and a rising edge on stop ends the measurement.
//   The interval in clk cycles is then sent LSB-first as ceil(CNT_W/8) bytes
//   over a valid/ready byte stream (toward a Uart instance). If the count
//   saturates before stop arrives, all-ones is sent and overflow is raised.
//
//   Build option: define TDC_HEADER_EN to prefix every frame with HEADER_BYTE.
//
// Parameters
//   CNT_W        interval counter width in bits (8..32)
//   HEADER_BYTE  frame sync byte (only used with TDC_HEADER_EN)
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   measurement start level (rising edge arms)
//   stop       in   measurement stop level (rising edge ends)
//   axi_valid  out  byte-stream valid
//   axi_ready  in   byte-stream ready
//   axi_data   out  byte-stream data [7:0]
//   busy       out  high while counting or sending
//   overflow   out  high when the last measurement saturated
module tdc_framer #(
  parameter int unsigned CNT_W       = 24,
  parameter logic [7:0]  HEADER_BYTE = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  output logic       axi_valid,
  input  logic       axi_ready,
  output logic [7:0] axi_data,
  output logic       busy,
  output logic       overflow
);

  localparam int unsigned NB = (CNT_W + 7) / 8;
`ifdef TDC_HEADER_EN
  localparam int unsigned NFRAME = NB + 1;
`else
  localparam int unsigned NFRAME = NB;
`endif
  localparam int unsigned IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    SEND  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                start_q, stop_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NB*8-1:0]     shreg_q, shreg_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                ovf_q, ovf_d;

  logic start_rise;
  logic stop_rise;
  logic sat;
  logic xfer;
  logic last;

  assign start_rise = start & ~start_q;
  assign stop_rise  = stop & ~stop_q;
  // Counter already holds all-ones: one more cycle cannot be represented.
  assign sat        = &cnt_q;
  assign xfer       = axi_valid & axi_ready;
  assign last       = (idx_q == IDX_W'(NFRAME - 1));

  // Edge-detect history keeps updating in every state so a level held
  // through SEND never shows up as a late edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      start_q <= 1'b1;
      stop_q  <= 1'b1;
    end else begin
      start_q <= start;
      stop_q  <= stop;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_rise) begin
          state_d = COUNT;
        end
      end
      COUNT: begin
        if (sat || stop_rise) begin
          state_d = SEND;
        end
      end
      SEND: begin
        if (xfer && last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath next-state
  always_comb begin
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start_rise) begin
          cnt_d = '0;
          ovf_d = 1'b0;
          idx_d = '0;
        end
      end
      COUNT: begin
        idx_d = '0;
        // cnt_q holds (cycles since the start edge) - 1, so the result
        // latched on a stop edge is cnt_q + 1.
        if (sat) begin
          shreg_d              = '0;
          shreg_d[CNT_W-1:0]   = '1;
          ovf_d                = 1'b1;
        end else if (stop_rise) begin
          shreg_d              = '0;
          shreg_d[CNT_W-1:0]   = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SEND: begin
        if (xfer) begin
          idx_d = last ? '0 : idx_q + IDX_W'(1);
`ifdef TDC_HEADER_EN
          if (idx_q != '0) begin
            shreg_d = shreg_q >> 8;
          end
`else
          shreg_d = shreg_q >> 8;
`endif
        end
      end
      default: begin
        idx_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      shreg_q <= '0;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
    end
  end

  // Output logic
  always_comb begin
    axi_valid = 1'b0;
    axi_data  = 8'h00;
    busy      = (state_q != IDLE);
    overflow  = ovf_q;
    if (state_q == SEND) begin
      axi_valid = 1'b1;
`ifdef TDC_HEADER_EN
      axi_data  = (idx_q == '0) ? HEADER_BYTE : shreg_q[7:0];
`else
      axi_data  = shreg_q[7:0];
`endif
    end
  end

endmodule

// File: tb/tb_tdc_framer.sv
module tb_tdc_framer;

`ifdef TDC_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start_a, stop_a, ready_a;
  logic       valid_a, busy_a, ovf_a;
  logic [7:0] data_a;
  logic       start_b, stop_b, ready_b;
  logic       valid_b, busy_b, ovf_b;
  logic [7:0] data_b;

  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];
  int tests = 0;
  int fails = 0;
  int xfer_a = 0;
  int xfer_b = 0;

  always #5 clk = ~clk;

  tdc_framer #(.CNT_W(24), .HEADER_BYTE(8'hA5)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .stop(stop_a),
    .axi_valid(valid_a), .axi_ready(ready_a), .axi_data(data_a),
    .busy(busy_a), .overflow(ovf_a)
  );

  tdc_framer #(.CNT_W(8), .HEADER_BYTE(8'hA5)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .stop(stop_b),
    .axi_valid(valid_b), .axi_ready(ready_b), .axi_data(data_b),
    .busy(busy_b), .overflow(ovf_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    if (HDR != 0) exp_a.push_back(8'hA5);
    exp_a.push_back(b0);
    exp_a.push_back(b1);
    exp_a.push_back(b2);
  endtask

  task automatic push_b(input logic [7:0] b0);
    if (HDR != 0) exp_b.push_back(8'hA5);
    exp_b.push_back(b0);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0 || busy_a || busy_b) && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_drain_timeout"}, {31'b0, n >= 100}, 32'd0);
  endtask

  // Scoreboard: every offered byte is compared with the queue head; it is
  // popped only when the handshake completes.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid_a) begin
        check("a_unexpected_byte", {31'b0, exp_a.size() != 0}, 32'd1);
        if (exp_a.size() != 0) begin
          check("a_byte", {24'b0, data_a}, {24'b0, exp_a[0]});
          if (ready_a) begin
            void'(exp_a.pop_front());
            xfer_a++;
          end
        end
      end
      if (valid_b) begin
        check("b_unexpected_byte", {31'b0, exp_b.size() != 0}, 32'd1);
        if (exp_b.size() != 0) begin
          check("b_byte", {24'b0, data_b}, {24'b0, exp_b[0]});
          if (ready_b) begin
            void'(exp_b.pop_front());
            xfer_b++;
          end
        end
      end
    end
  end

  initial begin
    int x0;
    rst = 1'b1;
    start_a = 1'b0; stop_a = 1'b0; ready_a = 1'b1;
    start_b = 1'b0; stop_b = 1'b0; ready_b = 1'b1;
    repeat (3) tick();
    check("rst_valid_a", {31'b0, valid_a}, 32'd0);
    check("rst_data_a", {24'b0, data_a}, 32'd0);
    check("rst_busy_a", {31'b0, busy_a}, 32'd0);
    check("rst_ovf_a", {31'b0, ovf_a}, 32'd0);
    check("rst_valid_b", {31'b0, valid_b}, 32'd0);
    check("rst_busy_b", {31'b0, busy_b}, 32'd0);
    rst = 1'b0;
    repeat (2) tick();

    // Stop edge alone in IDLE is ignored
    stop_a = 1'b1;
    tick();
    check("idle_stop_busy", {31'b0, busy_a}, 32'd0);
    stop_a = 1'b0;
    tick();

    // Scenario 1: N = 300 -> 2C 01 00
    push_a(8'h2C, 8'h01, 8'h00);
    start_a = 1'b1;
    repeat (300) tick();
    check("s1_busy_count", {31'b0, busy_a}, 32'd1);
    check("s1_valid_count", {31'b0, valid_a}, 32'd0);
    stop_a = 1'b1;
    tick();
    check("s1_valid_send", {31'b0, valid_a}, 32'd1);
    drain("s1");
    check("s1_ovf", {31'b0, ovf_a}, 32'd0);
    check("s1_busy_after", {31'b0, busy_a}, 32'd0);
    check("s1_valid_after", {31'b0, valid_a}, 32'd0);
    start_a = 1'b0; stop_a = 1'b0;
    repeat (2) tick();

    // Minimum interval N = 1
    push_a(8'h01, 8'h00, 8'h00);
    start_a = 1'b1;
    tick();
    stop_a = 1'b1;
    tick();
    drain("min");
    start_a = 1'b0; stop_a = 1'b0;
    repeat (2) tick();

    // Simultaneous start+stop in IDLE arms only; later stop gives N = 2
    push_a(8'h02, 8'h00, 8'h00);
    start_a = 1'b1; stop_a = 1'b1;
    tick();
    check("sim_busy", {31'b0, busy_a}, 32'd1);
    stop_a = 1'b0;
    tick();
    check("sim_still_count", {31'b0, valid_a}, 32'd0);
    stop_a = 1'b1;
    tick();
    drain("sim");
    start_a = 1'b0; stop_a = 1'b0;
    repeat (2) tick();

    // Scenario 3: backpressure, N = 5
    push_a(8'h05, 8'h00, 8'h00);
    x0 = xfer_a;
    ready_a = 1'b0;
    start_a = 1'b1;
    repeat (5) tick();
    stop_a = 1'b1;
    tick();
    for (int i = 0; i < 20 && exp_a.size() != 0; i++) begin
      ready_a = 1'b0;
      repeat (4) tick();
      ready_a = 1'b1;
      tick();
    end
    check("s3_xfer_count", 32'(xfer_a - x0), 32'(3 + HDR));
    drain("s3");
    ready_a = 1'b1;
    start_a = 1'b0; stop_a = 1'b0;
    repeat (2) tick();

    // Scenario 5: second start at T0+10 ignored, stop at T0+40, stop in SEND ignored
    push_a(8'h28, 8'h00, 8'h00);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (9) tick();
    start_a = 1'b1;
    tick();
    repeat (29) tick();
    stop_a = 1'b1;
    tick();
    stop_a = 1'b0;
    tick();
    stop_a = 1'b1;
    tick();
    drain("s5");
    repeat (3) tick();
    check("s5_no_extra_busy", {31'b0, busy_a}, 32'd0);
    start_a = 1'b0; stop_a = 1'b0;
    repeat (2) tick();

    // Scenario 6: reset after first byte consumed
    if (HDR != 0) exp_a.push_back(8'hA5);
    else exp_a.push_back(8'h03);
    start_a = 1'b1;
    repeat (3) tick();
    stop_a = 1'b1;
    tick();
    tick();
    check("s6_first_taken", 32'(exp_a.size()), 32'd0);
    rst = 1'b1;
    tick();
    check("s6_valid_after_rst", {31'b0, valid_a}, 32'd0);
    check("s6_data_after_rst", {24'b0, data_a}, 32'd0);
    check("s6_busy_after_rst", {31'b0, busy_a}, 32'd0);
    rst = 1'b0;
    repeat (5) tick();
    check("s6_held_start_no_meas", {31'b0, busy_a}, 32'd0);
    check("s6_no_valid", {31'b0, valid_a}, 32'd0);
    start_a = 1'b0; stop_a = 1'b0;
    repeat (2) tick();

    // Scenario 4: CNT_W = 8, no stop -> saturate to FF with overflow
    start_b = 1'b1;
    tick();
    repeat (255) tick();
    check("s4_not_yet_send", {31'b0, valid_b}, 32'd0);
    check("s4_busy", {31'b0, busy_b}, 32'd1);
    push_b(8'hFF);
    tick();
    check("s4_send_entered", {31'b0, valid_b}, 32'd1);
    check("s4_ovf_set", {31'b0, ovf_b}, 32'd1);
    drain("s4");
    check("s4_ovf_hold", {31'b0, ovf_b}, 32'd1);
    start_b = 1'b0;
    repeat (2) tick();
    check("s4_ovf_hold_idle", {31'b0, ovf_b}, 32'd1);
    push_b(8'h01);
    start_b = 1'b1;
    tick();
    check("s4_ovf_cleared", {31'b0, ovf_b}, 32'd0);
    stop_b = 1'b1;
    tick();
    drain("s4b");
    check("s4b_ovf", {31'b0, ovf_b}, 32'd0);
    start_b = 1'b0; stop_b = 1'b0;
    repeat (3) tick();
    check("end_queue_a", 32'(exp_a.size()), 32'd0);
    check("end_queue_b", 32'(exp_b.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tdc_framer.md
TDC_FRAMER -- requirements
Module: tdc_framer

Interface
REQ-001 SHALL have parameter CNT_W, default 24, meaning interval counter width in bits (8..32); the frame byte count NB SHALL be ceil(CNT_W/8).
REQ-002 SHALL have parameter HEADER_BYTE, default 8'hA5, meaning the frame sync byte used when TDC_HEADER_EN is defined.
REQ-003 SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port start, input, 1, measurement start; clk-synchronous level; its rising edge arms the measurement.
REQ-006 SHALL have port stop, input, 1, measurement stop; clk-synchronous level; its rising edge ends the measurement.
REQ-007 SHALL have port axi_valid, output, 1, byte-stream valid toward the Uart instance.
REQ-008 SHALL have port axi_ready, input, 1, byte-stream ready from the Uart instance.
REQ-009 SHALL have port axi_data, output, 8, byte-stream data.
REQ-010 SHALL have port busy, output, 1, high in COUNT or SEND.
REQ-011 SHALL have port overflow, output, 1, high when the last measurement saturated.

Function
REQ-012 SHALL detect a rising edge on start or stop as the input high in the current cycle and its registered copy low.
REQ-013 SHALL implement the FSM states IDLE, COUNT and SEND.
REQ-014 IDLE: a start edge SHALL clear the counter, clear overflow and enter COUNT in the next cycle.
REQ-015 A start edge detected at cycle T0 and a stop edge detected at cycle T0+N SHALL produce result N; the minimum valid N is 1.
REQ-016 A stop edge in IDLE SHALL be ignored; simultaneous start and stop edges in IDLE SHALL arm only, with the stop ignored.
REQ-017 COUNT: further start edges SHALL be ignored; a stop edge SHALL latch the result into the shift register and enter SEND.
REQ-018 COUNT: if the result would exceed 2^CNT_W-1, the result SHALL saturate at all-ones, overflow SHALL be set, and the FSM SHALL enter SEND without waiting for a stop edge.
REQ-019 SEND: axi_valid SHALL be high and axi_data SHALL carry the current frame byte, with result bytes sent LSB-first and the unused upper bits of the last byte zero.
REQ-020 A byte SHALL be consumed only in a cycle where axi_valid and axi_ready are both high; axi_data SHALL be held stable while axi_valid is high and axi_ready is low.
REQ-021 After the last byte is consumed, axi_valid SHALL be low in the next cycle and the FSM SHALL return to IDLE; back-to-back frames SHALL have at least one idle cycle between them.
REQ-022 Start and stop edges in SEND SHALL be ignored, but the edge-detect registers SHALL keep updating so that a level held across SEND produces no later edge.
REQ-023 overflow SHALL hold its value until the next accepted start edge.

Reset
REQ-024 While rst is high: state SHALL be IDLE, axi_valid 0, axi_data 8'h00, busy 0, overflow 0, counter 0, and byte index 0.
REQ-025 Edge-detect registers SHALL reset to 1, so an input already high when reset is released produces no edge.
REQ-026 Reset asserted mid-COUNT or mid-SEND SHALL abort the frame, and axi_valid SHALL be low in the cycle after the rst sample.

Configuration
REQ-027 SHALL use the macro TDC_HEADER_EN to select frame format.
REQ-028 With TDC_HEADER_EN defined, each frame SHALL be HEADER_BYTE followed by the NB result bytes, for NB+1 transfers.
REQ-029 Without TDC_HEADER_EN, each frame SHALL be the NB result bytes only, and no header logic SHALL be present.

Verification
REQ-030 Scenario 1 (CNT_W=24, no header, axi_ready tied 1): start edge at T0, stop edge at T0+300 -> bytes 2C, 01, 00 on consecutive cycles; overflow 0; busy low after the last byte.
REQ-031 Scenario 2 (header enabled): same stimulus as scenario 1 -> bytes A5, 2C, 01, 00.
REQ-032 Scenario 3 (backpressure): N=5, axi_ready low for 4 cycles per byte -> axi_data holds 05, then 00, then 00, each stable while not ready; exactly 3 transfers occur.
REQ-033 Scenario 4 (CNT_W=8, no stop) -> after 255 cycles the FSM enters SEND with byte FF and overflow 1; a following start edge clears overflow.
REQ-034 Scenario 5 (ignored edges): a second start edge at T0+10 and stop edge at T0+40 -> result 40 (byte 28); a stop edge during SEND changes nothing.
REQ-035 Scenario 6 (reset mid-send): rst pulsed after the first byte is consumed -> axi_valid low next cycle, no further bytes; start held high through reset release produces no measurement.
